// File: rtl/fht_but_feed_pkg.sv
// Shared definitions for the FHT butterfly operand feeder: default widths
// and the feeder FSM state encoding.
package fht_pkg;

  localparam int D_BIT_DEF = 17;                     // data sample width
  localparam int W_BIT_DEF = 12;                     // twiddle width
  localparam int A_BIT_DEF = 8;                      // log2 of transform length
  localparam int W_MAX_DEF = 2 ** (W_BIT_DEF - 2);   // cos value meaning 1.0

  typedef enum logic [2:0] {
    IDLE,
    RD0,
    RD1,
    RD2,
    FLUSH
  } feed_state_e;

endpackage

// File: rtl/fht_but_feed_if.sv
// Memory/butterfly bus of the FHT feeder: data RAM read port, twiddle ROM
// port and the registered operand set handed to the butterfly.
interface fht_but_feed_if
  import fht_pkg::*;
#(
  parameter int D_BIT = D_BIT_DEF,
  parameter int W_BIT = W_BIT_DEF,
  parameter int A_BIT = A_BIT_DEF
);

  logic                    oRD_EN;
  logic [A_BIT-1:0]        oRD_ADDR;
  logic signed [D_BIT-1:0] iRD_DATA;

  logic [A_BIT-2:0]        oROM_ADDR;
  logic signed [W_BIT-1:0] iROM_SIN;
  logic signed [W_BIT-1:0] iROM_COS;

  logic signed [D_BIT-1:0] oX_0;
  logic signed [D_BIT-1:0] oX_1;
  logic signed [D_BIT-1:0] oX_2;
  logic signed [W_BIT-1:0] oSIN;
  logic signed [W_BIT-1:0] oCOS;
  logic [A_BIT-1:0]        oWR_ADDR_0;
  logic [A_BIT-1:0]        oWR_ADDR_1;
  logic                    oVALID;
  logic                    oLAST;

  // The feeder drives addresses and operands, memories answer with data.
  modport master (
    output oRD_EN, oRD_ADDR, oROM_ADDR,
    output oX_0, oX_1, oX_2, oSIN, oCOS, oWR_ADDR_0, oWR_ADDR_1, oVALID, oLAST,
    input  iRD_DATA, iROM_SIN, iROM_COS
  );

  modport slave (
    input  oRD_EN, oRD_ADDR, oROM_ADDR,
    input  oX_0, oX_1, oX_2, oSIN, oCOS, oWR_ADDR_0, oWR_ADDR_1, oVALID, oLAST,
    output iRD_DATA, iROM_SIN, iROM_COS
  );

endinterface

// File: rtl/fht_but_feed_addr.sv
// Butterfly index arithmetic for one FHT stage: from butterfly number b and
// stage s produce the three data indices and the twiddle ROM address.
module fht_feed_addr
  import fht_pkg::*;
#(
  parameter int A_BIT = A_BIT_DEF
) (
  input  logic [A_BIT-2:0] b_i,
  input  logic [3:0]       s_i,
  output logic [A_BIT-1:0] k0_o,
  output logic [A_BIT-1:0] k1_o,
  output logic [A_BIT-1:0] k2_o,
  output logic [A_BIT-2:0] rom_addr_o,
  output logic             j_zero_o
);

  // One spare bit so g + 2h never wraps before truncation.
  localparam int XW = A_BIT + 1;

  logic [XW-1:0] bx;
  logic [XW-1:0] h;
  logic [XW-1:0] j;
  logic [XW-1:0] g;

  // h = 2^s, j = b mod h, g = (b div h) * 2h, then the three indices.
  always_comb begin
    bx         = XW'(b_i);
    h          = XW'(1) << s_i;
    j          = bx & (h - XW'(1));
    g          = (bx - j) << 1;
    k0_o       = A_BIT'(g + j);
    k1_o       = A_BIT'(g + h + j);
    j_zero_o   = (j == '0);
    k2_o       = j_zero_o ? k1_o : A_BIT'(g + (h << 1) - j);
    rom_addr_o = (A_BIT-1)'(j << (A_BIT - 1 - int'(s_i)));
  end

endmodule

// File: rtl/fht_but_feed.sv
// FHT butterfly operand feeder: walks every butterfly of one stage, reads
// k0/k1/k2 from the data RAM and the twiddle from the ROM, and presents a
// registered operand set with oVALID, one butterfly per 3 cycles.
// Optional feature: FHT_FEED_J0_SKIP_EN makes j=0 butterflies skip the k2
// read (oX_2 = k1 data, oSIN = 0, oCOS = W_MAX), taking 2 cycles each.
module fht_but_feed
  import fht_pkg::*;
#(
  parameter int D_BIT = D_BIT_DEF,
  parameter int W_BIT = W_BIT_DEF,
  parameter int A_BIT = A_BIT_DEF,
  parameter int W_MAX = 2 ** (W_BIT - 2)
) (
  input  logic         iCLK,
  input  logic         iRESET,
  input  logic         iSTART,
  input  logic [3:0]   iSTAGE,
  output logic         oBUSY,
  fht_but_feed_if.master bus
);

`ifdef FHT_FEED_J0_SKIP_EN
  localparam bit J0_SKIP = 1'b1;
`else
  localparam bit J0_SKIP = 1'b0;
`endif

  feed_state_e state_q, state_d;
  logic [A_BIT-2:0] b_q, b_d;
  logic [3:0]       stage_q;
  logic             busy_q;
  logic             start_ok;
  logic             last_b;

  logic [A_BIT-1:0] k0, k1, k2;
  logic [A_BIT-2:0] rom_addr;
  logic             j_zero;

  logic             rd_en;
  logic [A_BIT-1:0] rd_addr;
  logic [A_BIT-2:0] rom_addr_out;
  logic             capture_d, cap_skip_d;

  // Operands in flight for the butterfly being captured next cycle.
  logic signed [D_BIT-1:0] hold0_q, hold1_q;
  logic             cap_q, cap_skip_q, last_pend_q;
  logic [A_BIT-1:0] wr0_pend_q, wr1_pend_q;

  // Registered operand set seen by the butterfly.
  logic signed [D_BIT-1:0] x0_q, x1_q, x2_q;
  logic signed [W_BIT-1:0] sin_q, cos_q;
  logic [A_BIT-1:0] wr0_q, wr1_q;
  logic             valid_q, last_q;

  fht_feed_addr #(.A_BIT(A_BIT)) u_addr (
    .b_i        (b_q),
    .s_i        (stage_q),
    .k0_o       (k0),
    .k1_o       (k1),
    .k2_o       (k2),
    .rom_addr_o (rom_addr),
    .j_zero_o   (j_zero)
  );

  assign last_b = (b_q == '1);

  // Next-state, read strobes and capture scheduling.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // through the case leaves a signal unassigned and no latch is inferred.
    state_d      = state_q;
    b_d          = b_q;
    start_ok     = 1'b0;
    rd_en        = 1'b0;
    rd_addr      = '0;
    rom_addr_out = '0;
    capture_d    = 1'b0;
    cap_skip_d   = 1'b0;
    case (state_q)
      IDLE: begin
        // The final oVALID cycle is spent in IDLE with busy still high.
        if (iSTART && !busy_q && (int'(iSTAGE) < A_BIT)) begin
          start_ok = 1'b1;
          b_d      = '0;
          state_d  = RD0;
        end
      end
      RD0: begin
        rd_en   = 1'b1;
        rd_addr = k0;
        state_d = RD1;
      end
      RD1: begin
        rd_en   = 1'b1;
        rd_addr = k1;
        if (J0_SKIP && j_zero) begin
          capture_d  = 1'b1;
          cap_skip_d = 1'b1;
          b_d        = b_q + 1'b1;
          state_d    = last_b ? FLUSH : RD0;
        end else begin
          state_d = RD2;
        end
      end
      RD2: begin
        rd_en        = 1'b1;
        rd_addr      = k2;
        rom_addr_out = rom_addr;
        capture_d    = 1'b1;
        b_d          = b_q + 1'b1;
        state_d      = last_b ? FLUSH : RD0;
      end
      FLUSH:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM state, butterfly counter, stage and busy flag.
  always_ff @(posedge iCLK or negedge iRESET) begin
    if (!iRESET) begin
      state_q <= IDLE;
      b_q     <= '0;
      stage_q <= '0;
      busy_q  <= 1'b0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every flop
      // samples the pre-edge values regardless of statement order.
      state_q <= state_d;
      b_q     <= b_d;
      if (start_ok) begin
        stage_q <= iSTAGE;
        busy_q  <= 1'b1;
      end else if (valid_q && last_q) begin
        busy_q  <= 1'b0;
      end
    end
  end

  // Hold k0/k1 data, remember the pending butterfly, then load the outputs.
  always_ff @(posedge iCLK or negedge iRESET) begin
    if (!iRESET) begin
      // NOTE: the data holds are ordinary flops, not a RAM, so they are
      // cleared with everything else and no stale operand survives reset.
      hold0_q     <= '0;
      hold1_q     <= '0;
      cap_q       <= 1'b0;
      cap_skip_q  <= 1'b0;
      last_pend_q <= 1'b0;
      wr0_pend_q  <= '0;
      wr1_pend_q  <= '0;
      x0_q        <= '0;
      x1_q        <= '0;
      x2_q        <= '0;
      sin_q       <= '0;
      cos_q       <= '0;
      wr0_q       <= '0;
      wr1_q       <= '0;
      valid_q     <= 1'b0;
      last_q      <= 1'b0;
    end else begin
      if (state_q == RD1) hold0_q <= bus.iRD_DATA;
      if (state_q == RD2) hold1_q <= bus.iRD_DATA;
      cap_q      <= capture_d;
      cap_skip_q <= cap_skip_d;
      if (capture_d) begin
        wr0_pend_q  <= k0;
        wr1_pend_q  <= k1;
        last_pend_q <= last_b;
      end
      valid_q <= cap_q;
      if (cap_q) begin
        x0_q   <= hold0_q;
        x1_q   <= cap_skip_q ? bus.iRD_DATA : hold1_q;
        x2_q   <= bus.iRD_DATA;
        sin_q  <= cap_skip_q ? '0 : bus.iROM_SIN;
        cos_q  <= cap_skip_q ? W_BIT'(W_MAX) : bus.iROM_COS;
        wr0_q  <= wr0_pend_q;
        wr1_q  <= wr1_pend_q;
        last_q <= last_pend_q;
      end
    end
  end

  assign oBUSY          = busy_q;
  assign bus.oRD_EN     = rd_en;
  assign bus.oRD_ADDR   = rd_addr;
  assign bus.oROM_ADDR  = rom_addr_out;
  assign bus.oX_0       = x0_q;
  assign bus.oX_1       = x1_q;
  assign bus.oX_2       = x2_q;
  assign bus.oSIN       = sin_q;
  assign bus.oCOS       = cos_q;
  assign bus.oWR_ADDR_0 = wr0_q;
  assign bus.oWR_ADDR_1 = wr1_q;
  assign bus.oVALID     = valid_q;
  assign bus.oLAST      = last_q;

endmodule

// File: doc/fht_but_feed.md
FHT_BUT_FEED -- requirements
Module: fht_but_feed

Interface
REQ-001 Parameter D_BIT, default 17: data sample width, signed two's complement.
REQ-002 Parameter W_BIT, default 12: twiddle width, signed.
REQ-003 Parameter A_BIT, default 8: log2 of transform length N.
REQ-004 Parameter W_MAX, default 2^(W_BIT-2): cos value representing 1.0.
REQ-005 iCLK  in  1  clock; all state changes on its rising edge.
REQ-006 iRESET  in  1  reset, asynchronous, active-low.
REQ-007 iSTART  in  1  one-cycle request to run one stage.
REQ-008 iSTAGE  in  4  stage index s, sampled with accepted iSTART.
REQ-009 oBUSY  out  1  stage in progress.
REQ-010 oRD_EN / oRD_ADDR  out  1 / A_BIT  data RAM read strobe and address.
REQ-011 iRD_DATA  in  D_BIT  RAM data, valid one cycle after oRD_EN.
REQ-012 oROM_ADDR  out  A_BIT-1  twiddle ROM address.
REQ-013 iROM_SIN / iROM_COS  in  W_BIT each  ROM data, valid one cycle after oROM_ADDR.
REQ-014 oX_0, oX_1, oX_2  out  D_BIT each  butterfly operands.
REQ-015 oSIN, oCOS  out  W_BIT each  butterfly twiddle.
REQ-016 oWR_ADDR_0 / oWR_ADDR_1  out  A_BIT each  destination indices k0 and k1 for the butterfly outputs.
REQ-017 oVALID / oLAST  out  1 / 1  operand set valid, one cycle / final set of the stage.

Function
REQ-018 The block SHALL feed every butterfly of stage s, with h = 2^s and N/2 butterflies, ordered by index b = 0..N/2-1.
REQ-019 For butterfly b: j = b mod h, g = (b div h)*2h, k0 = g+j, k1 = g+h+j, k2 = k1 if j=0 else g+2h-j.
REQ-020 ROM address SHALL be j << (A_BIT-1-s).
REQ-021 The FSM SHALL have states IDLE, RD0, RD1, RD2, FLUSH.
REQ-022 An iSTART in IDLE with iSTAGE < A_BIT SHALL set oBUSY on the next edge and enter RD0 with b=0.
REQ-023 iSTART while busy, or with iSTAGE >= A_BIT, SHALL be ignored.
REQ-024 RD0 drives k0, RD1 drives k1, and RD2 drives k2 together with the ROM address; oRD_EN SHALL be high in all three states.
REQ-025 Data for k0 and k1 SHALL be held internally. At the end of the cycle after RD2, oX_0/oX_1/oX_2/oSIN/oCOS/oWR_ADDR_* SHALL load and oVALID SHALL be 1 for one cycle.
REQ-026 Latency SHALL be 4 cycles from the RD0 cycle to the oVALID cycle.
REQ-027 The RD0 of the next butterfly SHALL overlap the capture cycle, giving throughput of one butterfly per 3 cycles with no bubbles.
REQ-028 After RD2 of b = N/2-1, the FSM SHALL go to FLUSH, then to IDLE.
REQ-029 The final oVALID SHALL carry oLAST=1, and oBUSY SHALL drop on the following edge.
REQ-030 Output registers SHALL hold their value between oVALID pulses, and oRD_EN SHALL be 0 in IDLE and FLUSH.
REQ-031 Stage 0 (h=1) SHALL always have j=0, k2=k1 and ROM address 0.

Reset
REQ-032 On iRESET low, the block SHALL immediately enter IDLE, set b=0, and clear all outputs, holds and strobes to 0, including mid-stage; no further oVALID is produced.
REQ-033 After reset release, the block SHALL wait for a new iSTART.

Configuration
REQ-034 With FHT_FEED_J0_SKIP_EN defined, a j=0 butterfly SHALL skip RD2 and present oX_2 = k1 data, oSIN = 0, oCOS = W_MAX; it takes 2 cycles with latency 3, and oRD_EN/oROM_ADDR are not driven for k2.
REQ-035 Without FHT_FEED_J0_SKIP_EN, every butterfly SHALL take 3 reads per REQ-024.

Structure
REQ-036 Package fht_pkg SHALL hold D_BIT, W_BIT, A_BIT, W_MAX defaults and the FSM state enumeration.
REQ-037 Sub-module fht_feed_addr SHALL compute k0/k1/k2/ROM address combinationally from b and s; the FSM and capture registers stay in fht_but_feed.

Verification (A_BIT=4, N=16, RAM[i]=i, ROM[m]=(sin=m, cos=100+m))
REQ-038 Stage 2, b=5 -> reads 9,13,15, ROM addr 2, and oVALID with X=(9,13,15), SIN=2, COS=102, WR=(9,13).
REQ-039 Stage 0 full run -> 8 oVALID pulses spaced 3 cycles, first 4 cycles after the first RD0, last with oLAST, oBUSY low one cycle later.
REQ-040 Stage 3 -> b=0 gives X=(0,8,8), ROM 0; b=7 gives X=(7,15,9), ROM 7.
REQ-041 iSTART during busy, and iSTART with iSTAGE=4 -> no effect, and the pulse count is unchanged.
REQ-042 Reset asserted after the third oVALID of stage 1 -> outputs are 0 immediately, no further oVALID, and a new iSTART restarts at b=0.
REQ-043 With FHT_FEED_J0_SKIP_EN, stage 1 -> j=0 butterflies have 2-cycle spacing, oX_2 = oX_1, oSIN=0, oCOS=W_MAX.
